// File: rtl/servant_boot_defs.sv
// Shared definitions for the flash boot loader: SPI opcode and FSM encoding.
package servant_boot_defs;

   localparam logic [7:0] SPI_CMD_READ = 8'h03;
   localparam int         SPI_WORD_BITS = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      DATA   = 3'd2,
      WRITE  = 3'd3,
      FINISH = 3'd4,
      DONE   = 3'd5
   } boot_state_t;

endpackage

// File: rtl/servant_boot_spi.sv
// Mode-0 SPI engine: SCK divider plus 32-bit shifter, one word per start pulse.
module servant_boot_spi
   import servant_boot_defs::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] tx_word,
   input  logic        rx_mode,
   input  logic        miso,
   output logic        busy,
   output logic [31:0] rx_word,
   output logic        sck,
   output logic        mosi
);

   localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_reg;
   logic [5:0]       bit_cnt_reg;
   logic [30:0]      tx_reg;
   logic [31:0]      rx_reg;
   logic             mode_reg;
   logic             busy_reg;
   logic             sck_reg;
   logic             mosi_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg     <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= '0;
         rx_reg      <= '0;
         mode_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         sck_reg     <= 1'b0;
         mosi_reg    <= 1'b0;
      end else if (start) begin
         div_reg     <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= tx_word[30:0];
         mode_reg    <= rx_mode;
         busy_reg    <= 1'b1;
         sck_reg     <= 1'b0;
         mosi_reg    <= rx_mode ? 1'b0 : tx_word[31];
      end else if (busy_reg) begin
         if (div_reg == DIV_LAST) begin
            div_reg <= '0;
            sck_reg <= ~sck_reg;
            if (!sck_reg) begin
               rx_reg      <= {rx_reg[30:0], miso};
               bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (bit_cnt_reg == 6'(SPI_WORD_BITS)) begin
               // Word complete: SCK is now back low and MOSI parks at 0.
               busy_reg <= 1'b0;
               mosi_reg <= 1'b0;
            end else begin
               tx_reg   <= {tx_reg[29:0], 1'b0};
               mosi_reg <= mode_reg ? 1'b0 : tx_reg[30];
            end
         end else begin
            div_reg <= div_reg + 1'b1;
         end
      end
   end

   assign busy    = busy_reg;
   assign rx_word = rx_reg;
   assign sck     = sck_reg;
   assign mosi    = mosi_reg;

endmodule

// File: rtl/servant_flash_boot.sv
// Boot loader: reads an image from SPI flash and writes it to RAM over Wishbone,
// holding the CPU in reset until the copy is complete.
module servant_flash_boot
   import servant_boot_defs::*;
#(
   parameter logic [23:0] FLASH_ADDR = 24'h100000,
   parameter int          WORDS      = 2048,
   parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
   parameter int          CLK_DIV    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic        i_wb_ack,
   output logic        o_flash_sck,
   output logic        o_flash_csn,
   output logic        o_flash_mosi,
   input  logic        i_flash_miso,
   output logic        o_cpu_rst,
   output logic        o_done
);

   localparam int IDX_W = (WORDS < 1) ? 1 : $clog2(WORDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   boot_state_t      state_reg, state_next;
   logic [IDX_W-1:0] index_reg, index_next;
   logic             cyc_reg, cyc_next;
   logic [31:0]      adr_reg, adr_next;
   logic [31:0]      dat_reg, dat_next;
   logic             csn_reg, csn_next;

   logic        spi_start;
   logic        spi_rx_mode;
   logic [31:0] spi_tx;
   logic        spi_busy;
   logic [31:0] spi_rx;
   logic [31:0] rx_swapped;

   // Flash bytes arrive in address order; the first one lands in the low byte.
   for (genvar gi = 0; gi < 4; gi++) begin : g_swap
      assign rx_swapped[8*gi +: 8] = spi_rx[8*(3-gi) +: 8];
   end

   servant_boot_spi #(.CLK_DIV(CLK_DIV)) u_spi (
      .clk     (i_clk),
      .rst     (i_rst),
      .start   (spi_start),
      .tx_word (spi_tx),
      .rx_mode (spi_rx_mode),
      .miso    (i_flash_miso),
      .busy    (spi_busy),
      .rx_word (spi_rx),
      .sck     (o_flash_sck),
      .mosi    (o_flash_mosi)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
         index_reg <= '0;
         cyc_reg   <= 1'b0;
         adr_reg   <= RAM_BASE;
         dat_reg   <= '0;
         csn_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         cyc_reg   <= cyc_next;
         adr_reg   <= adr_next;
         dat_reg   <= dat_next;
         csn_reg   <= csn_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      index_next  = index_reg;
      cyc_next    = cyc_reg;
      adr_next    = adr_reg;
      dat_next    = dat_reg;
      csn_next    = csn_reg;
      spi_start   = 1'b0;
      spi_rx_mode = 1'b1;
      spi_tx      = '0;
      case (state_reg)
         IDLE: begin
            if (WORDS == 0) begin
               state_next = DONE;
            end else begin
               csn_next    = 1'b0;
               spi_start   = 1'b1;
               spi_rx_mode = 1'b0;
               spi_tx      = {SPI_CMD_READ, FLASH_ADDR};
               state_next  = CMD;
            end
         end
         CMD: begin
            if (!spi_busy) begin
               spi_start  = 1'b1;
               state_next = DATA;
            end
         end
         DATA: begin
            if (!spi_busy) begin
               cyc_next   = 1'b1;
               adr_next   = RAM_BASE + (32'(index_reg) << 2);
               dat_next   = rx_swapped;
               state_next = WRITE;
            end
         end
         WRITE: begin
            if (i_wb_ack) begin
               cyc_next   = 1'b0;
               index_next = index_reg + 1'b1;
               if (index_reg == LAST_IDX) begin
                  csn_next   = 1'b1;
                  state_next = FINISH;
               end else begin
                  spi_start  = 1'b1;
                  state_next = DATA;
               end
            end
         end
         FINISH:  state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   assign o_wb_adr    = adr_reg;
   assign o_wb_dat    = dat_reg;
   assign o_wb_sel    = 4'hF;
   assign o_wb_we     = cyc_reg;
   assign o_wb_cyc    = cyc_reg;
   assign o_flash_csn = csn_reg;
   assign o_done      = (state_reg == DONE);
   assign o_cpu_rst   = (state_reg != DONE);

endmodule
